clock_set_ctrl: RTL and testbench

Time-setting controller for the 24-hour clock. It consumes the one-cycle button pulses from the debounced button front end and the 1 Hz tick, and drives the hour/minute/second counter datapath with count, increment and clear strobes. It also drives the display blanking signals so the field being edited blinks. It sits between the button input block and the time counters.

---
 rtl/clock_set_ctrl.sv | 106 ++++++++++
 tb/tb_clock_set_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/clock_set_ctrl.sv
// Time-setting controller for the 24-hour clock: mode FSM, edit strobes,
// idle timeout back to RUN and blink blanking of the field being edited.
module clock_set_ctrl #(
    parameter int unsigned BLINK_HALF  = 12000000,
    parameter int unsigned TIMEOUT_SEC = 30
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [2:0] BTN,
    input  logic       EN1HZ,
    output logic       COUNT_EN,
    output logic       HOUR_INC,
    output logic       MIN_INC,
    output logic       SEC_CLR,
    output logic [1:0] STATE,
    output logic [2:0] BLANK
);

    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_SET_HOUR = 2'd1;
    localparam logic [1:0] ST_SET_MIN  = 2'd2;
    localparam logic [1:0] ST_SET_SEC  = 2'd3;

    localparam logic [23:0] BLINK_LAST = 24'(BLINK_HALF - 1);
    localparam logic [5:0]  IDLE_LAST  = 6'(TIMEOUT_SEC - 1);

    logic [1:0]  state_q, state_d;
    logic [5:0]  idle_q, idle_d;
    logic [23:0] blink_q, blink_d;
    logic        phase_q, phase_d;
    logic [2:0]  blank_d;
    logic        btn_any, mode_p, sel_p, up_p, timeout, state_chg;

    always_comb begin
        btn_any = |BTN;
        // Only the highest-priority button of a cycle is acted on.
        mode_p  = BTN[0];
        sel_p   = BTN[1] & ~BTN[0];
        up_p    = BTN[2] & ~BTN[1] & ~BTN[0];
        timeout = (state_q != ST_RUN) && EN1HZ && !btn_any && (idle_q == IDLE_LAST);

        state_d = state_q;
        if (mode_p) begin
            state_d = (state_q == ST_RUN) ? ST_SET_HOUR : ST_RUN;
        end else if (sel_p && (state_q != ST_RUN)) begin
            state_d = (state_q == ST_SET_SEC) ? ST_SET_HOUR : state_q + 2'd1;
        end else if (timeout) begin
            state_d = ST_RUN;
        end
        state_chg = (state_d != state_q);

        idle_d = idle_q;
        if (state_chg || btn_any) begin
            idle_d = 6'd0;
        end else if ((state_q != ST_RUN) && EN1HZ) begin
            idle_d = idle_q + 6'd1;
        end

        // A press or mode change restarts the blink visible so edits show at once.
        blink_d = blink_q;
        phase_d = phase_q;
        if (state_chg || btn_any) begin
            blink_d = 24'd0;
            phase_d = 1'b0;
        end else if (blink_q == BLINK_LAST) begin
            blink_d = 24'd0;
            phase_d = ~phase_q;
        end else begin
            blink_d = blink_q + 24'd1;
        end

        case (state_d)
            ST_SET_HOUR: blank_d = {phase_d, 2'b00};
            ST_SET_MIN:  blank_d = {1'b0, phase_d, 1'b0};
            ST_SET_SEC:  blank_d = {2'b00, phase_d};
            default:     blank_d = 3'b000;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= ST_RUN;
            idle_q   <= 6'd0;
            blink_q  <= 24'd0;
            phase_q  <= 1'b0;
            COUNT_EN <= 1'b0;
            HOUR_INC <= 1'b0;
            MIN_INC  <= 1'b0;
            SEC_CLR  <= 1'b0;
            BLANK    <= 3'b000;
        end else begin
            state_q  <= state_d;
            idle_q   <= idle_d;
            blink_q  <= blink_d;
            phase_q  <= phase_d;
            COUNT_EN <= EN1HZ && (state_q == ST_RUN);
            HOUR_INC <= up_p && (state_q == ST_SET_HOUR);
            MIN_INC  <= up_p && (state_q == ST_SET_MIN);
            SEC_CLR  <= up_p && (state_q == ST_SET_SEC);
            BLANK    <= blank_d;
        end
    end

    assign STATE = state_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Scoreboard bench for clock_set_ctrl: stimulus queues expected output events,
// a monitor pops one whenever a strobe fires or STATE changes.
module tb_clock_set_ctrl;

    typedef struct packed {
        logic       ce;
        logic       hi;
        logic       mi;
        logic       sc;
        logic [1:0] st;
        logic [2:0] bl;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] btn;
    logic       en1hz;
    logic       count_en, hour_inc, min_inc, sec_clr;
    logic [1:0] state;
    logic [2:0] blank;

    ev_t        exp_q[$];
    logic [2:0] blank_q[$];
    bit         blink_on = 1'b0;
    int         vectors = 0;
    int         miscompares = 0;
    logic [1:0] prev_st = 2'd0;
    ev_t        act_ev;

    always #5 clk = ~clk;

    clock_set_ctrl #(
        .BLINK_HALF (4),
        .TIMEOUT_SEC(3)
    ) dut (
        .CLK     (clk),
        .RST     (rst),
        .BTN     (btn),
        .EN1HZ   (en1hz),
        .COUNT_EN(count_en),
        .HOUR_INC(hour_inc),
        .MIN_INC (min_inc),
        .SEC_CLR (sec_clr),
        .STATE   (state),
        .BLANK   (blank)
    );

    function automatic void chk(input string name, input logic [8:0] act, input logic [8:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, req, $time);
        end
    endfunction

    function automatic void expect_ev(input bit ce, input bit hi, input bit mi, input bit sc,
                                      input logic [1:0] st);
        exp_q.push_back({ce, hi, mi, sc, st, 3'b000});
    endfunction

    task automatic cyc(input logic [2:0] b, input logic e, input logic r = 1'b0);
        @(negedge clk);
        btn   = b;
        en1hz = e;
        rst   = r;
    endtask

    // Monitor: samples 1 time unit after each active edge.
    always begin
        @(posedge clk);
        #1;
        act_ev = {count_en, hour_inc, min_inc, sec_clr, state, blank};
        if ((act_ev.ce | act_ev.hi | act_ev.mi | act_ev.sc) === 1'b1 || act_ev.st !== prev_st) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_event: got %b, expected none (t=%0t)", act_ev, $time);
            end else begin
                chk("event", act_ev, exp_q.pop_front());
            end
        end
        prev_st = state;
        if (blink_on) begin
            if (blank_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL blink_underflow: got %b, expected none", blank);
            end else begin
                chk("blank", {6'd0, blank}, {6'd0, blank_q.pop_front()});
            end
        end
    end

    initial begin
        rst   = 1'b1;
        btn   = 3'b000;
        en1hz = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset", {count_en, hour_inc, min_inc, sec_clr, state, blank}, 9'd0);
        cyc(3'b000, 1'b0);

        // RUN: ticks pass through one cycle later
        repeat (3) begin
            expect_ev(1, 0, 0, 0, 2'd0);
            cyc(3'b000, 1'b1);
            cyc(3'b000, 1'b0);
            cyc(3'b000, 1'b0);
        end

        // Edit sequence, with ticks in set states that must not count
        expect_ev(0, 0, 0, 0, 2'd1); cyc(3'b001, 1'b0);
        repeat (5) begin
            expect_ev(0, 1, 0, 0, 2'd1);
            cyc(3'b100, 1'b0);
        end
        cyc(3'b000, 1'b0);
        cyc(3'b000, 1'b1);
        cyc(3'b000, 1'b0);
        expect_ev(0, 0, 0, 0, 2'd2); cyc(3'b010, 1'b0);
        repeat (2) begin
            expect_ev(0, 0, 1, 0, 2'd2);
            cyc(3'b100, 1'b0);
        end
        expect_ev(0, 0, 0, 0, 2'd3); cyc(3'b010, 1'b0);
        expect_ev(0, 0, 0, 1, 2'd3); cyc(3'b100, 1'b0);
        cyc(3'b000, 1'b1);
        expect_ev(0, 0, 0, 0, 2'd0); cyc(3'b001, 1'b0);
        cyc(3'b000, 1'b0);

        // Button priority and MODE coincident with a tick
        expect_ev(0, 0, 0, 0, 2'd1); cyc(3'b111, 1'b0);
        expect_ev(0, 0, 0, 0, 2'd2); cyc(3'b110, 1'b0);
        expect_ev(0, 0, 0, 0, 2'd0); cyc(3'b001, 1'b0);
        cyc(3'b000, 1'b0);
        expect_ev(1, 0, 0, 0, 2'd1); cyc(3'b001, 1'b1);
        expect_ev(0, 0, 0, 0, 2'd0); cyc(3'b001, 1'b1);
        cyc(3'b000, 1'b0);

        // Blink in SET_MIN, half period 4, restarted by UP
        expect_ev(0, 0, 0, 0, 2'd1); cyc(3'b001, 1'b0);
        expect_ev(0, 0, 0, 0, 2'd2); cyc(3'b010, 1'b0);
        blank_q = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b010, 3'b010,
                    3'b000, 3'b000, 3'b000, 3'b000, 3'b010, 3'b010};
        blink_on = 1'b1;
        repeat (5) cyc(3'b000, 1'b0);
        expect_ev(0, 0, 1, 0, 2'd2); cyc(3'b100, 1'b0);
        repeat (5) cyc(3'b000, 1'b0);
        @(negedge clk);
        blink_on = 1'b0;
        expect_ev(0, 0, 0, 0, 2'd0); cyc(3'b001, 1'b0);
        cyc(3'b000, 1'b0);

        // Idle timeout after 3 ticks
        expect_ev(0, 0, 0, 0, 2'd1); cyc(3'b001, 1'b0);
        cyc(3'b000, 1'b1);
        cyc(3'b000, 1'b0);
        cyc(3'b000, 1'b1);
        cyc(3'b000, 1'b0);
        expect_ev(0, 0, 0, 0, 2'd0); cyc(3'b000, 1'b1);
        cyc(3'b000, 1'b0);
        cyc(3'b000, 1'b0);

        // Press on the third tick holds off the timeout
        expect_ev(0, 0, 0, 0, 2'd1); cyc(3'b001, 1'b0);
        cyc(3'b000, 1'b1);
        cyc(3'b000, 1'b0);
        cyc(3'b000, 1'b1);
        cyc(3'b000, 1'b0);
        expect_ev(0, 1, 0, 0, 2'd1); cyc(3'b100, 1'b1);
        cyc(3'b000, 1'b1);
        cyc(3'b000, 1'b0);
        expect_ev(0, 0, 0, 0, 2'd0); cyc(3'b001, 1'b0);
        cyc(3'b000, 1'b0);

        // Reset coincident with UP in SET_MIN
        expect_ev(0, 0, 0, 0, 2'd1); cyc(3'b001, 1'b0);
        expect_ev(0, 0, 0, 0, 2'd2); cyc(3'b010, 1'b0);
        expect_ev(0, 0, 0, 0, 2'd0); cyc(3'b100, 1'b0, 1'b1);
        cyc(3'b000, 1'b0);
        repeat (3) cyc(3'b000, 1'b0);
        @(negedge clk);

        if (exp_q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL missing_events: got %0d left over, expected 0", exp_q.size());
        end
        if (blank_q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL missing_blank: got %0d left over, expected 0", blank_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
